cpu_ctrl: RTL
=============

Name: cpu_ctrl

Overview:
Multi-cycle control unit for the 4-bit CPU. It fetches 8-bit instructions, decodes them, and sequences the register file. It drives the two read selects, the write select and write enable, the ALU opcode and the writeback source mux. It also owns the PC and the zero flag, and handles jumps and halt.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
run  in  1  permits leaving FETCH; low holds the CPU in FETCH
instr  in  8  instruction memory data; combinational read of address pc, valid in the same cycle
alu_zero  in  1  ALU result==0, valid while sel_a/sel_b/alu_op are stable
pc  out  PC_W  instruction address
sel_a  out  2  register file read port A select (operand / destination rd)
sel_b  out  2  register file read port B select (source rs)
sel_w  out  2  register file write select
write_en  out  1  register file write enable, one-cycle pulse
alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
wb_src  out  2  writeback mux: 00 ALU, 01 imm, 10 port B passthrough
imm  out  4  immediate nibble from second instruction byte
z_flag  out  1  registered zero flag
halted  out  1  high in HALT state

Behaviour:
- Instruction byte: op=instr[7:4], rd=instr[3:2], rs=instr[1:0]. Ops: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR (rd<=rd op rs, updates Z); 5 MOV (rd<=rs, Z unchanged); 6 LDI (2-byte, rd<=byte2[3:0]); 7 JMP (2-byte, pc<=byte2); 8 JZ (2-byte, jump if z_flag); F HLT. Undefined opcodes (9-E) execute as NOP.
- Registers: IR[7:0], OPR[7:0] (second byte), pc, z_flag, state.
- States: FETCH, FETCH2, EXEC, WB, HALT.
- FETCH: if run, IR<=instr, pc<=pc+1, then go to FETCH2 if op in {6,7,8}, else EXEC. If !run, hold. Decode uses the instr input directly in this cycle.
- FETCH2: OPR<=instr, pc<=pc+1, then EXEC.
- EXEC: sel_a=IR.rd, sel_b=IR.rs, alu_op=op-1 for ops 1-4.
  - JMP: pc<=OPR[PC_W-1:0].
  - JZ: pc<=OPR when z_flag=1.
  - HLT: go to HALT.
  - NOP/JMP/JZ/undefined: back to FETCH.
  - ADD/SUB/AND/OR/MOV/LDI: go to WB.
- WB: sel_a/sel_b/alu_op held from EXEC; sel_w=IR.rd; write_en=1 for exactly this cycle. The register file captures at the end-of-WB clock edge.
  - wb_src: 00 for ALU ops, 01 for LDI, 10 for MOV.
  - ALU ops: z_flag<=alu_zero at the same edge.
  - Next state: FETCH.
- Cycle counts: ALU/MOV 3 cycles; LDI 4; JMP/JZ 3; NOP 2.
- HALT: absorbing; only rst exits. write_en=0; pc frozen.
- imm = OPR[3:0] at all times.
- PC wraps modulo 2^PC_W on increment (all-ones + 1 -> 0).
- write_en is 0 in every state except WB. Outputs are decoded from state and IR, so there are no glitching writes outside WB.
- Reset values: state=FETCH, pc=RESET_PC, IR=0, OPR=0, z_flag=0, write_en=0, sel_a=sel_b=sel_w=0, alu_op=0, wb_src=0, halted=0. Reset takes priority over all transitions, including mid-instruction (e.g. in WB: no write occurs at that edge).
- run deasserted mid-instruction does not stall; it is sampled only in FETCH.

Test Plan:
- Reset then run=1 with LDI r1 (0x64, 0x05): pc 0->2; write_en high exactly one cycle with sel_w=1, wb_src=01, imm=5; 4 cycles total.
- ADD r1,r2 (0x16) with alu_zero=1 during WB: sel_a=1, sel_b=2, alu_op=00, write_en pulse with sel_w=1; z_flag=1 afterwards. SUB (0x2B) with alu_zero=0 -> alu_op=01, z_flag=0.
- JZ 0x40 (0x80, 0x40): with z_flag=1 -> pc=0x40 after EXEC; with z_flag=0 -> pc=prior+2; write_en never asserted.
- PC wrap: RESET_PC=0xFF, NOP (0x00) -> pc=0x00 after FETCH.
- HLT (0xF0): halted=1 and pc frozen for 20+ cycles, write_en=0. Assert rst -> pc=RESET_PC, halted=0 next cycle.
- rst asserted during WB of MOV r3,r0 (0x5C): no write edge occurs; all outputs at reset values. run=0 held in FETCH: pc constant, IR unchanged.

Source files
------------

// File: rtl/cpu_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_if
// Bundles the signals between the CPU control unit and the rest of the 4-bit
// CPU (instruction memory, register file, ALU, writeback mux).
//
//   run, instr, alu_zero               : into the control unit
//   pc                                 : instruction address
//   sel_a, sel_b, sel_w, write_en      : register file control
//   alu_op, wb_src, imm                : ALU opcode, writeback source, immediate
//   z_flag, halted                     : architectural status
//   state_dbg                          : current FSM state, for observation only
//
// Write strobe contract (there is no valid/ready pair on this bus): write_en is
// a single-cycle strobe. The register file must capture at the rising edge
// that ends the cycle in which write_en is high, using the sel_w, wb_src and
// imm values of that same cycle. There is no back-pressure. alu_zero must
// reflect the register file and ALU outputs for the current sel_a, sel_b and
// alu_op within the same cycle.
//
// master: the control unit. slave: the datapath / environment.
// ---------------------------------------------------------------------------
interface cpu_ctrl_if #(
    parameter int PC_W = 8
);
    logic            run;
    logic [7:0]      instr;
    logic            alu_zero;
    logic [PC_W-1:0] pc;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic [1:0]      sel_w;
    logic            write_en;
    logic [1:0]      alu_op;
    logic [1:0]      wb_src;
    logic [3:0]      imm;
    logic            z_flag;
    logic            halted;
    logic [2:0]      state_dbg;

    modport master (
        input  run, instr, alu_zero,
        output pc, sel_a, sel_b, sel_w, write_en, alu_op, wb_src, imm,
               z_flag, halted, state_dbg
    );

    modport slave (
        output run, instr, alu_zero,
        input  pc, sel_a, sel_b, sel_w, write_en, alu_op, wb_src, imm,
               z_flag, halted, state_dbg
    );
endinterface

// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl
// Multi-cycle control unit for the 4-bit CPU. Fetches one- or two-byte
// instructions, sequences the register file and ALU, owns pc and the zero
// flag, and implements JMP, JZ and HLT.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : cpu_ctrl_if.master (instruction fetch, register file control,
//          status and the state_dbg observation output)
//
// Parameters:
//   PC_W     : program counter width
//   RESET_PC : pc value loaded on reset
// ---------------------------------------------------------------------------
module cpu_ctrl #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       rst,
    cpu_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FETCH2 = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t          state, state_nxt;
    logic [7:0]      ir, ir_nxt;
    logic [7:0]      opr, opr_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic            z, z_nxt;

    logic [3:0]      ir_op;
    logic [3:0]      fetch_op;
    logic            ir_is_alu;
    logic [3:0]      op_m1;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jump_target;

    assign ir_op       = ir[7:4];
    assign fetch_op    = bus.instr[7:4];
    assign ir_is_alu   = (ir_op >= 4'h1) && (ir_op <= 4'h4);
    assign op_m1       = ir_op - 4'h1;
    // Natural width wrap gives all-ones + 1 -> 0.
    assign pc_inc      = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign jump_target = PC_W'(opr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= 8'h00;
            opr   <= 8'h00;
            pc    <= RESET_PC;
            z     <= 1'b0;
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
            opr   <= opr_nxt;
            pc    <= pc_nxt;
            z     <= z_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        opr_nxt   = opr;
        pc_nxt    = pc;
        z_nxt     = z;
        case (state)
            S_FETCH: begin
                if (bus.run) begin
                    // Length is decoded from the raw memory byte because IR
                    // only captures it at the end of this cycle.
                    ir_nxt = bus.instr;
                    pc_nxt = pc_inc;
                    if (fetch_op == OP_LDI || fetch_op == OP_JMP || fetch_op == OP_JZ)
                        state_nxt = S_FETCH2;
                    else
                        state_nxt = S_EXEC;
                end
            end
            S_FETCH2: begin
                opr_nxt   = bus.instr;
                pc_nxt    = pc_inc;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (ir_op == OP_JMP) begin
                    pc_nxt    = jump_target;
                    state_nxt = S_FETCH;
                end else if (ir_op == OP_JZ) begin
                    if (z)
                        pc_nxt = jump_target;
                    state_nxt = S_FETCH;
                end else if (ir_op == OP_HLT) begin
                    state_nxt = S_HALT;
                end else if (ir_is_alu || ir_op == OP_MOV || ir_op == OP_LDI) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                if (ir_is_alu)
                    z_nxt = bus.alu_zero;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Outputs are decoded only from state and IR so nothing can glitch a write.
    always_comb begin
        bus.sel_a    = 2'b00;
        bus.sel_b    = 2'b00;
        bus.sel_w    = 2'b00;
        bus.write_en = 1'b0;
        bus.alu_op   = 2'b00;
        bus.wb_src   = 2'b00;
        if (state == S_EXEC || state == S_WB) begin
            bus.sel_a = ir[3:2];
            bus.sel_b = ir[1:0];
            if (ir_is_alu)
                bus.alu_op = op_m1[1:0];
        end
        if (state == S_WB) begin
            bus.sel_w = ir[3:2];
            // A reset landing on the WB edge must not let the register file write.
            bus.write_en = !rst;
            if (ir_op == OP_LDI)
                bus.wb_src = 2'b01;
            else if (ir_op == OP_MOV)
                bus.wb_src = 2'b10;
        end
    end

    assign bus.pc        = pc;
    assign bus.imm       = opr[3:0];
    assign bus.z_flag    = z;
    assign bus.halted    = (state == S_HALT);
    assign bus.state_dbg = state;

endmodule
